// File: rtl/digit_argmax.sv
// digit_argmax
// Sequential arg-max back-end for the classifier's final layer. A full set of
// signed scores is snapshotted on a valid/ready handshake, then scanned one
// element per clock through a single comparator pair. The winning index, its
// score and the margin over the runner-up are registered and held until the
// consumer accepts them.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data while valid is high and ready is low.
// in_ready is high only in IDLE. out_valid stays high, with stable results,
// until out_ready is seen.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   scores     N_CLASSES signed scores, element i is class i
//   in_valid   scores valid for capture
//   in_ready   block can accept a score set (IDLE)
//   out_valid  result valid, held until accepted
//   out_ready  consumer accepts the result
//   class_idx  index of the maximum score
//   best_score maximum score (signed)
//   margin     best minus second-best, DATA_W+1 bits, never negative
//   busy       high while scanning or holding a result
//   state_dbg  current FSM state encoding (IDLE=0, SCAN=1, DONE=2)
module digit_argmax #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 128,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] scores [N_CLASSES],
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] best_score,
    output logic [DATA_W:0]   margin,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]         LAST_PTR = IDX_W'(N_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state, state_next;

    logic signed [DATA_W-1:0] snap [N_CLASSES];
    logic signed [DATA_W-1:0] best, second;
    logic [IDX_W-1:0]         idx, ptr;

    logic signed [DATA_W-1:0] cur, best_nx, second_nx;
    logic [IDX_W-1:0]         idx_nx;
    logic                     last;

    assign cur  = snap[ptr];
    assign last = (ptr == LAST_PTR);

    // One comparator pair shared across the whole scan. Strict greater-than
    // keeps the lowest index on ties; a tied later value falls through to the
    // second-best path, which yields a zero margin.
    always_comb begin
        best_nx   = best;
        second_nx = second;
        idx_nx    = idx;
        if (cur > best) begin
            second_nx = best;
            best_nx   = cur;
            idx_nx    = ptr;
        end else if (cur > second) begin
            second_nx = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SCAN;
            SCAN:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SCAN) || (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CLASSES; i++) snap[i] <= '0;
            best       <= '0;
            second     <= '0;
            idx        <= '0;
            ptr        <= '0;
            out_valid  <= 1'b0;
            class_idx  <= '0;
            best_score <= '0;
            margin     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_CLASSES; i++) snap[i] <= scores[i];
                        // Element 0 seeds the running best; the scan starts at 1.
                        best   <= scores[0];
                        second <= MOST_NEG;
                        idx    <= '0;
                        ptr    <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    best   <= best_nx;
                    second <= second_nx;
                    idx    <= idx_nx;
                    if (last) begin
                        out_valid  <= 1'b1;
                        class_idx  <= idx_nx;
                        best_score <= best_nx;
                        // Sign-extend both operands so the difference of the
                        // two extremes still fits.
                        margin     <= {best_nx[DATA_W-1], best_nx}
                                    - {second_nx[DATA_W-1], second_nx};
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_argmax.sv
// Testbench for digit_argmax: table of score sets with hand-derived results,
// random score sets checked against a reference model, and hand-written
// sequences for handshake overlap and reset during a scan.
module tb_digit_argmax;

    localparam int N     = 10;
    localparam int W     = 128;
    localparam int IW    = 4;
    localparam int CW    = W + 1;
    localparam int RES_W = IW + W + W + 1;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  best;
        logic [W:0]    margin;
    } res_t;

    typedef struct {
        logic [N*W-1:0] flat;
        res_t           exp;
        int             hold;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  scores [N];
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] class_idx;
    logic [W-1:0]  best_score;
    logic [W:0]    margin;
    logic          busy;
    logic [1:0]    state_dbg;

    logic [RES_W-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;
    vec_t tbl [7];

    always #5 clk = ~clk;

    digit_argmax #(.N_CLASSES(N), .DATA_W(W), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .scores    (scores),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_idx (class_idx),
        .best_score(best_score),
        .margin    (margin),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sv(input int v);
        logic signed [W-1:0] t;
        t = W'(v);
        return t;
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = v;
        return f;
    endfunction

    function automatic logic [N*W-1:0] pack_ints(input int a [N]);
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = sv(a[i]);
        return f;
    endfunction

    // Reference: first index holding the maximum, then the largest value
    // among all other positions.
    function automatic res_t model(input logic [N*W-1:0] f);
        logic signed [W-1:0] s [N];
        logic signed [W-1:0] sec;
        int   bi;
        res_t r;
        for (int i = 0; i < N; i++) s[i] = f[i*W +: W];
        bi = 0;
        for (int i = 1; i < N; i++) if (s[i] > s[bi]) bi = i;
        sec = MOST_NEG;
        for (int j = 0; j < N; j++) if (j != bi && s[j] > sec) sec = s[j];
        r.idx    = IW'(bi);
        r.best   = s[bi];
        r.margin = {s[bi][W-1], s[bi]} - {sec[W-1], sec};
        return r;
    endfunction

    task automatic drive_scores(input logic [N*W-1:0] f);
        for (int i = 0; i < N; i++) scores[i] = f[i*W +: W];
    endtask

    // Offers one score set; returns at the falling edge after the capture edge
    // with the scores input already overwritten by unrelated values.
    task automatic start_capture(input logic [N*W-1:0] f, input res_t e);
        @(negedge clk);
        drive_scores(f);
        in_valid = 1'b1;
        check("in_ready_idle", CW'(in_ready), CW'(1));
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        drive_scores(fill(sv(1000)));
        check("busy_after_capture", CW'(busy), CW'(1));
    endtask

    task automatic wait_done(output res_t e);
        int lat;
        lat = 0;
        e = '0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", CW'(lat), CW'(N - 1));
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: result seen with empty expected queue");
        end else begin
            e = res_t'(exp_q.pop_front());
            check("class_idx", CW'(class_idx), CW'(e.idx));
            check("best_score", CW'(best_score), CW'(e.best));
            check("margin", margin, e.margin);
        end
    endtask

    task automatic handshake(input res_t e, input int hold);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", CW'(out_valid), CW'(1));
            check("hold_in_ready", CW'(in_ready), CW'(0));
            check("hold_busy", CW'(busy), CW'(1));
            check("hold_class_idx", CW'(class_idx), CW'(e.idx));
            check("hold_best", CW'(best_score), CW'(e.best));
            check("hold_margin", margin, e.margin);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("accept_out_valid", CW'(out_valid), CW'(0));
        check("accept_in_ready", CW'(in_ready), CW'(1));
        check("accept_busy", CW'(busy), CW'(0));
        check("kept_class_idx", CW'(class_idx), CW'(e.idx));
        check("kept_best", CW'(best_score), CW'(e.best));
        check("kept_margin", margin, e.margin);
    endtask

    task automatic run_vec(input vec_t v);
        res_t e;
        start_capture(v.flat, v.exp);
        wait_done(e);
        handshake(e, v.hold);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, CW'(in_ready), CW'(1));
        check({tag, "_out_valid"}, CW'(out_valid), CW'(0));
        check({tag, "_busy"}, CW'(busy), CW'(0));
        check({tag, "_class_idx"}, CW'(class_idx), CW'(0));
        check({tag, "_best"}, CW'(best_score), CW'(0));
        check({tag, "_margin"}, margin, CW'(0));
    endtask

    initial begin
        int   a [N];
        res_t e;
        vec_t rv;

        // Clock/reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_scores('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // Stimulus table with hand-derived results
        a = '{0, 1, 2, 3, 4, 50, 6, 7, 8, 9};
        tbl[0].flat = pack_ints(a);
        tbl[0].exp  = '{IW'(5), sv(50), CW'(41)};
        tbl[0].hold = 0;

        a = '{-100, -100, -100, -7, -100, -100, -100, -100, -7, -100};
        tbl[1].flat = pack_ints(a);
        tbl[1].exp  = '{IW'(3), sv(-7), CW'(0)};
        tbl[1].hold = 20;

        tbl[2].flat = fill(MOST_NEG);
        tbl[2].flat[0 +: W] = MAX_POS;
        tbl[2].exp  = '{IW'(0), MAX_POS, {1'b0, {W{1'b1}}}};
        tbl[2].hold = 2;

        a = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 6};
        tbl[3].flat = pack_ints(a);
        tbl[3].exp  = '{IW'(9), sv(6), CW'(1)};
        tbl[3].hold = 1;

        a = '{42, 42, 42, 42, 42, 42, 42, 42, 42, 42};
        tbl[4].flat = pack_ints(a);
        tbl[4].exp  = '{IW'(0), sv(42), CW'(0)};
        tbl[4].hold = 0;

        a = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        tbl[5].flat = pack_ints(a);
        tbl[5].exp  = '{IW'(0), sv(9), CW'(1)};
        tbl[5].hold = 3;

        a = '{-5, 20, 3, 19, 0, 0, 0, 0, 0, 0};
        tbl[6].flat = pack_ints(a);
        tbl[6].exp  = '{IW'(1), sv(20), CW'(1)};
        tbl[6].hold = 0;

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Random score sets checked against the model
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < N; j++) a[j] = int'($urandom_range(0, 200)) - 100;
            rv.flat = pack_ints(a);
            rv.exp  = model(rv.flat);
            rv.hold = int'($urandom_range(0, 3));
            run_vec(rv);
        end

        // in_valid in the acceptance cycle is taken only on the following cycle
        start_capture(tbl[0].flat, tbl[0].exp);
        wait_done(e);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_scores(tbl[5].flat);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("overlap_out_valid", CW'(out_valid), CW'(0));
        check("overlap_in_ready", CW'(in_ready), CW'(1));
        check("overlap_busy", CW'(busy), CW'(0));
        exp_q.push_back(tbl[5].exp);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        drive_scores(fill(sv(1000)));
        check("overlap_captured_busy", CW'(busy), CW'(1));
        wait_done(e);
        handshake(e, 0);

        // Reset in the middle of a scan discards the partial result
        start_capture(tbl[6].flat, tbl[6].exp);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midscan_reset");
        void'(exp_q.pop_front());
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("post_reset_no_result", CW'(out_valid), CW'(0));
        end
        run_vec(tbl[0]);
        run_vec(tbl[2]);

        check("scoreboard_drained", CW'(exp_q.size()), CW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
